seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL provide parameter SEQ_LEN, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL provide parameter SEQ_PATTERN, default 4'b1011, target pattern, SEQ_LEN bits wide, MSB received first.
REQ-003 SHALL provide parameter OVERLAP, default 1, 1 = overlapping matches allowed, 0 = detector restarts after each match.
REQ-004 SHALL provide parameter CNT_W, default 8, width of the match counter.
REQ-005 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port i_rstn  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port i_valid  input  1  i_seq is accepted on an edge only when i_valid=1.
REQ-008 SHALL have port i_seq  input  1  serial data bit.
REQ-009 SHALL have port i_clr  input  1  synchronous clear of the FSM and the counter.
REQ-010 SHALL have port o_match  output  1  Moore match flag.
REQ-011 SHALL have port o_count  output  CNT_W  number of matches since reset or clear.

Function
REQ-012 SHALL implement the FSM with state S = number of pattern bits currently matched, range 0..SEQ_LEN, encoded in ceil(log2(SEQ_LEN+1)) bits.
REQ-013 SHALL compare each accepted bit against pattern bit SEQ_PATTERN[SEQ_LEN-1-S].
REQ-014 From S<SEQ_LEN, an accepted bit SHALL move the FSM to the length of the longest suffix of (matched prefix + bit) that is also a prefix of the pattern; for example, S=3 of 1011 with bit 0 goes to 2.
REQ-015 From S=SEQ_LEN with OVERLAP=1, the FSM SHALL first fall back to the longest proper border of the pattern and then apply REQ-014.
REQ-016 From S=SEQ_LEN with OVERLAP=0, the FSM SHALL first fall back to S=0 and then apply REQ-014.
REQ-017 When i_valid=0, the state, o_match and o_count SHALL hold unchanged.
REQ-018 o_match SHALL be decoded from state only, and SHALL be 1 iff S=SEQ_LEN.
REQ-019 o_match SHALL rise in the cycle after the edge that accepts the last pattern bit, which is a latency of 1 clock.
REQ-020 o_match SHALL stay high until the next accepted bit or clear.
REQ-021 o_count SHALL increment by 1 on each edge at which the FSM enters S=SEQ_LEN.
REQ-022 o_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 i_clr=1 SHALL set S to 0 and o_count to 0 on the next edge.
REQ-024 When i_clr and i_valid are both 1, i_clr SHALL take priority and the accepted bit SHALL be discarded.
REQ-025 Unreachable state encodings SHALL return to S=0 on the next edge, whether or not a bit is accepted.
REQ-026 Transition tables SHALL be derived at elaboration from the parameters, with no run-time pattern storage.

Reset
REQ-027 While i_rstn=0, the block SHALL immediately force S=0, o_match=0 and o_count=0, independent of i_clk.
REQ-028 Reset asserted mid-pattern SHALL discard any partial match.
REQ-029 The first bit accepted after i_rstn deasserts SHALL be evaluated from S=0.

Configuration
REQ-030 Macro SEQ_DETECT_PARAM_CNT_EN defined: o_count SHALL be implemented as specified in REQ-021 to REQ-023.
REQ-031 Macro SEQ_DETECT_PARAM_CNT_EN undefined: the counter register SHALL be omitted and o_count SHALL be tied to 0.
REQ-032 Behaviour of o_match SHALL be identical whether or not SEQ_DETECT_PARAM_CNT_EN is defined.

Verification
REQ-033 Bench SHALL cover: defaults, OVERLAP=1, i_valid=1, bits 1,0,1,1,0,1,1 -> o_match high after the 4th and 7th accepted bits; o_count=2.
REQ-034 Bench SHALL cover: the same stream with OVERLAP=0 -> o_match high only after the 4th bit; o_count=1.
REQ-035 Bench SHALL cover: bits 1,0,1 accepted, i_valid=0 for 5 cycles, then bit 1 -> o_match high the cycle after the final 1, with no change during the gap.
REQ-036 Bench SHALL cover: bits 1,0,1, then i_rstn pulsed low asynchronously between edges, then bit 1 -> o_match stays 0 and S=1.
REQ-037 Bench SHALL cover: CNT_W=2, 5 overlapping matches of 1011 -> o_count 1,2,3,3,3; then i_clr with i_valid=1 -> S=0 and o_count=0 with the bit discarded.
REQ-038 Bench SHALL cover: SEQ_LEN=3, SEQ_PATTERN=3'b111, OVERLAP=1, five 1s -> o_match high after bits 3, 4 and 5; o_count=3 with the macro defined, 0 without it.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector (Moore) with a saturating match counter.
// Define SEQ_DETECT_PARAM_CNT_EN to build the counter; otherwise o_count is tied to 0.
module seq_detect_param #(
  parameter int                 SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = SEQ_LEN'(4'b1011),
  parameter bit                 OVERLAP     = 1'b1,
  parameter int                 CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic             i_seq,
  input  logic             i_clr,
  output logic             o_match,
  output logic [CNT_W-1:0] o_count
);

  localparam int            SW     = $clog2(SEQ_LEN + 1);
  localparam logic [SW-1:0] S_FULL = SW'(SEQ_LEN);

  // Pattern bit i, counted in arrival order (i = 0 is the first bit received).
  function automatic bit pat_bit(int i);
    logic [SEQ_LEN-1:0] sh;
    sh = SEQ_PATTERN >> (SEQ_LEN - 1 - i);
    return sh[0];
  endfunction

  function automatic int border_len();
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < SEQ_LEN; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (pat_bit(j) != pat_bit(SEQ_LEN - k + j)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // Longest suffix of (matched prefix + b) that is also a pattern prefix.
  function automatic int next_len(int s, bit b);
    int base;
    int idx;
    bit ok;
    bit cand;
    base = (s >= SEQ_LEN) ? (OVERLAP ? border_len() : 0) : s;
    for (int k = base + 1; k >= 1; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        idx  = base + 1 - k + j;
        cand = (idx == base) ? b : pat_bit(idx);
        if (cand != pat_bit(j)) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  logic [SW-1:0] nxt0 [SEQ_LEN+1];
  logic [SW-1:0] nxt1 [SEQ_LEN+1];

  for (genvar g = 0; g <= SEQ_LEN; g++) begin : g_tbl
    localparam int N0 = next_len(g, 1'b0);
    localparam int N1 = next_len(g, 1'b1);
    assign nxt0[g] = SW'(N0);
    assign nxt1[g] = SW'(N1);
  end

  logic [SW-1:0] state_q, state_d;
  logic          st_bad;

  if ((2 ** SW) > (SEQ_LEN + 1)) begin : g_bad
    assign st_bad = (state_q > S_FULL);
  end else begin : g_nobad
    assign st_bad = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= '0;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clr)        state_d = '0;
    else if (st_bad)  state_d = '0;
    else if (i_valid) state_d = i_seq ? nxt1[state_q] : nxt0[state_q];
  end

  always_comb begin
    o_match = (state_q == S_FULL);
  end

`ifdef SEQ_DETECT_PARAM_CNT_EN
  logic [CNT_W-1:0] count_q, count_d;
  logic             enter_full;

  // Re-entering the full state from itself (overlap) counts as a new match.
  assign enter_full = i_valid && !i_clr && !st_bad && (state_d == S_FULL);

  always_comb begin
    count_d = count_q;
    if (i_clr)                             count_d = '0;
    else if (enter_full && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_count = count_q;
`else
  assign o_count = '0;
`endif

endmodule
